rf_multiport: RTL



---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_multiport_if.sv | 29 ++
 rtl/rf_read_lane.sv | 42 ++++
 rtl/rf_multiport.sv | 69 ++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  // Low bit of field idx in a packed vector of w-bit fields.
  function automatic int field_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Decode/writeback-facing bus of rf_multiport: write ports, read ports, ready.
interface rf_multiport_if
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                    ready;
  logic [NUM_WR-1:0]       we;
  logic [NUM_WR*AW-1:0]    waddr;
  logic [NUM_WR*WIDTH-1:0] wdata;
  logic [NUM_RD*AW-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rdata;

  modport master (
    input  ready, rdata,
    output we, waddr, wdata, raddr
  );

  modport slave (
    output ready, rdata,
    input  we, waddr, wdata, raddr
  );

endinterface

// File: rtl/rf_read_lane.sv
// One read port: array data, optional same-cycle write forwarding (RF_BYPASS_EN),
// hardwired zero register and gating to zero while the clear sweep runs.
module rf_read_lane
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int AW       = 5,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clear,
  input  logic [AW-1:0]           raddr,
  input  logic [WIDTH-1:0]        mem_data,
  input  logic [NUM_WR-1:0]       we,
  input  logic [NUM_WR*AW-1:0]    waddr,
  input  logic [NUM_WR*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]        rdata
);

`ifdef RF_BYPASS_EN
  // Ascending scan so the highest-index matching port overrides lower ones.
  always_comb begin
    rdata = mem_data;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && (waddr[field_lo(k, AW) +: AW] == raddr))
        rdata = wdata[field_lo(k, WIDTH) +: WIDTH];
    end
    if (clear || (ZERO_REG != 0 && raddr == '0))
      rdata = '0;
  end
`else
  logic unused_bypass;
  assign unused_bypass = &{1'b0, we, waddr, wdata};

  always_comb begin
    rdata = mem_data;
    if (clear || (ZERO_REG != 0 && raddr == '0))
      rdata = '0;
  end
`endif

endmodule

// File: rtl/rf_multiport.sv
// Parametrised N-read/M-write register file with post-reset clear sweep.
// Optional same-cycle write-to-read forwarding enabled by defining RF_BYPASS_EN.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_multiport_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  rf_state_e        state;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             clearing;

  assign clearing  = (state == RF_CLEAR);
  assign bus.ready = (state == RF_READY);

  // The sweep writes one entry per cycle so the array needs no reset and can map to RAM.
  // Later write ports are assigned last, so the highest index wins on an address clash.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RF_CLEAR;
      idx   <= '0;
    end else if (state == RF_CLEAR) begin
      mem[idx] <= '0;
      if (idx == AW'(DEPTH - 1))
        state <= RF_READY;
      else
        idx <= idx + 1'b1;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] && !(ZERO_REG != 0 && bus.waddr[field_lo(k, AW) +: AW] == '0))
          mem[bus.waddr[field_lo(k, AW) +: AW]] <= bus.wdata[field_lo(k, WIDTH) +: WIDTH];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_lane
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = bus.raddr[field_lo(j, AW) +: AW];
    assign bus.rdata[field_lo(j, WIDTH) +: WIDTH] = rd;

    rf_read_lane #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_lane (
      .clear    (clearing),
      .raddr    (ra),
      .mem_data (mem[ra]),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .rdata    (rd)
    );
  end

endmodule
